// File: rtl/keypad_scanner_pkg.sv
// Shared constants, FSM state type and small helpers for the keypad scanner.
// The blank digit and reset word are shared with the seven-segment display driver.
package keypad_scanner_pkg;

  localparam logic [3:0] COL0     = 4'b1110;
  localparam logic [3:0] COL1     = 4'b1101;
  localparam logic [3:0] COL2     = 4'b1011;
  localparam logic [3:0] COL3     = 4'b0111;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  localparam logic [3:0]  BLANK_DIGIT = 4'hE;
  localparam logic [15:0] NUMS_RESET  = {4{BLANK_DIGIT}};

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} scan_state_t;

  // Position of the lowest-numbered low bit in an active-low vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  function automatic logic [3:0] next_col(input logic [3:0] c);
    logic [3:0] n;
    case (c)
      COL0:    n = COL1;
      COL1:    n = COL2;
      COL2:    n = COL3;
      default: n = COL0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/keypad_frame_sampler.sv
// Scan divider, column rotation, row synchronizer and per-frame key detection.
// A frame is the four samples of columns 0..3; its result is valid while frame_done is high.
module keypad_frame_sampler
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       frame_done,
  output logic       frame_key_valid,
  output logic [3:0] frame_code
);

  logic [SCAN_DIV_BITS-1:0] div;
  logic                     tick;
  logic [3:0]               row_meta;
  logic [3:0]               row_sync;
  logic [1:0]               acc_hits;
  logic [3:0]               acc_code;
  logic [1:0]               total_hits;
  logic [3:0]               total_code;
  logic [3:0]               hit_sum;
  logic                     sampling;

  assign tick     = &div;
  assign sampling = tick && (col != COL_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      col      <= COL_IDLE;
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      div      <= div + 1'b1;
      row_meta <= row;
      row_sync <= row_meta;
      if (tick) col <= next_col(col);
    end
  end

  // Hit count saturates at 2: anything beyond one pressed pair is rejected anyway.
  always_comb begin
    hit_sum    = 4'(acc_hits) + 4'(low_count(row_sync));
    total_hits = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
    total_code = acc_code;
    if (acc_hits == 2'd0 && low_count(row_sync) == 3'd1)
      total_code = {low_index(row_sync), low_index(col)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hits <= 2'd0;
      acc_code <= 4'd0;
    end else if (sampling) begin
      if (col == COL3) begin
        acc_hits <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_hits <= total_hits;
        acc_code <= total_code;
      end
    end
  end

  assign frame_done      = tick && (col == COL3);
  assign frame_key_valid = (total_hits == 2'd1);
  assign frame_code      = total_code;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: debounces frame results into one pulse per press and
// keeps the last four accepted codes in a word for the display driver.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV_BITS  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] nums
);

  localparam logic [3:0] SCANS = 4'(DEBOUNCE_SCANS);

  logic        frame_done;
  logic        frame_key_valid;
  logic [3:0]  frame_code;
  scan_state_t state, state_next;
  logic [3:0]  cand, cand_next;
  logic [3:0]  cnt, cnt_next;
  logic [3:0]  rel, rel_next;
  logic        accept;

  keypad_frame_sampler #(
    .SCAN_DIV_BITS(SCAN_DIV_BITS)
  ) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .row             (row),
    .col             (col),
    .frame_done      (frame_done),
    .frame_key_valid (frame_key_valid),
    .frame_code      (frame_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= 4'd0;
      rel   <= 4'd0;
    end else begin
      state <= state_next;
      cand  <= cand_next;
      cnt   <= cnt_next;
      rel   <= rel_next;
    end
  end

  // The FSM only moves on frame boundaries; a multi-key frame counts as no key.
  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    rel_next   = rel;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_key_valid) begin
            cand_next  = frame_code;
            cnt_next   = 4'd1;
            state_next = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (accept) begin
            cnt_next   = 4'd0;
            rel_next   = 4'd0;
            state_next = HELD;
          end else if (frame_key_valid && frame_code == cand) begin
            cnt_next = cnt + 4'd1;
          end else if (frame_key_valid) begin
            cand_next = frame_code;
            cnt_next  = 4'd1;
          end else begin
            cnt_next   = 4'd0;
            state_next = IDLE;
          end
        end
        HELD: begin
          if (frame_key_valid) begin
            rel_next = 4'd0;
          end else if (rel + 4'd1 == SCANS) begin
            rel_next   = 4'd0;
            state_next = IDLE;
          end else begin
            rel_next = rel + 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    accept = frame_done && (state == DEBOUNCE) && frame_key_valid &&
             (frame_code == cand) && (cnt + 4'd1 == SCANS);
  end

  // Clear takes priority over a simultaneous accept for nums only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      nums      <= NUMS_RESET;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= cand;
      if (clear) nums <= NUMS_RESET;
      else if (accept) nums <= {nums[11:0], cand};
    end
  end

endmodule
